// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle control unit.
//   state_t       - FSM state encoding (also exported on the State debug port)
//   instr_class_t - instruction class produced by ctrl_opdecode
//   OP_*          - 6-bit primary opcodes (Instr[INSTR_W-1 -: 6])
//   ALU_*         - ALU function codes
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_B,
    CLS_BEQ,
    CLS_BNE,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: shared instruction/data memory port.
//   Instr    - memory read data (instruction or load data)
//   Mem_rdy  - access completes this cycle
//   Mem_req  - access request, held until Mem_rdy
//   Mem_WrEn - write qualifier for the current request
// master = control unit side, slave = memory side.
interface multicycle_control_if #(
  parameter int unsigned INSTR_W = 32
);
  logic [INSTR_W-1:0] Instr;
  logic               Mem_rdy;
  logic               Mem_req;
  logic               Mem_WrEn;

  modport master (input Instr, input Mem_rdy, output Mem_req, output Mem_WrEn);
  modport slave  (output Instr, output Mem_rdy, input Mem_req, input Mem_WrEn);
endinterface

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode decode for the multi-cycle controller.
//   opcode/func  - IR opcode field and R-type function field
//   iclass/legal - instruction class and legal-opcode flag
//   alu_func, alu_bin_sel, rf_b_sel, lui, lb, sb - datapath fields
// alu_bin_sel: 0 = register B, 1 = immediate. rf_b_sel: 0 = rt, 1 = rd
// (branches and stores read rd as the second source).
module ctrl_opdecode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_FUNC_W = 4
) (
  input  logic [5:0]            opcode,
  input  logic [ALU_FUNC_W-1:0] func,
  output instr_class_t          iclass,
  output logic                  legal,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  alu_bin_sel,
  output logic                  rf_b_sel,
  output logic                  lui,
  output logic                  lb,
  output logic                  sb
);

  always_comb begin
    iclass      = CLS_ILLEGAL;
    legal       = 1'b1;
    alu_func    = ALU_FUNC_W'(ALU_ADD);
    alu_bin_sel = 1'b1;
    rf_b_sel    = 1'b1;
    lui         = 1'b0;
    lb          = 1'b0;
    sb          = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass      = CLS_ALU;
        alu_func    = func;
        alu_bin_sel = 1'b0;
        rf_b_sel    = 1'b0;
      end
      OP_LI, OP_ADDI: iclass = CLS_ALU;
      OP_LUI: begin
        iclass = CLS_ALU;
        lui    = 1'b1;
      end
      OP_ANDI: begin
        iclass   = CLS_ALU;
        alu_func = ALU_FUNC_W'(ALU_AND);
      end
      OP_ORI: begin
        iclass   = CLS_ALU;
        alu_func = ALU_FUNC_W'(ALU_OR);
      end
      OP_B: iclass = CLS_B;
      OP_BEQ, OP_BNE: begin
        iclass      = (opcode == OP_BEQ) ? CLS_BEQ : CLS_BNE;
        alu_func    = ALU_FUNC_W'(ALU_SUB);
        alu_bin_sel = 1'b0;
      end
      OP_LB, OP_LW: begin
        iclass = CLS_LOAD;
        lb     = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        iclass = CLS_STORE;
        sb     = (opcode == OP_SB);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM control unit for a multi-cycle datapath with one
// shared instruction/data memory port.
//   clk, Reset_n  - clock, asynchronous active-low reset
//   mem           - memory port (Instr, Mem_rdy in; Mem_req, Mem_WrEn out)
//   Zero          - ALU zero flag, sampled in EXEC only
//   IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
//   ALU_func, lui, lb, sb - datapath controls
//   Trap, State   - sticky error flag, current state (debug)
// Optional: MULTICYCLE_CTRL_PERF_EN adds Cycle_cnt and Retired_cnt.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned ALU_FUNC_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  multicycle_control_if.master  mem,
  input  logic                  Zero,
  output logic                  IR_LdEn,
  output logic                  PC_sel,
  output logic                  PC_LdEn,
  output logic                  RF_WrEn,
  output logic                  RF_WrData_sel,
  output logic                  RF_B_sel,
  output logic                  ALU_Bin_sel,
  output logic [ALU_FUNC_W-1:0] ALU_func,
  output logic                  lui,
  output logic                  lb,
  output logic                  sb,
  output logic                  Trap,
  output logic [2:0]            State
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]           Cycle_cnt,
  output logic [31:0]           Retired_cnt
`endif
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t             state, state_next;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   wait_cnt;

  instr_class_t          dec_class;
  logic                  dec_legal;
  logic [ALU_FUNC_W-1:0] dec_func;
  logic                  dec_bin, dec_rfb, dec_lui, dec_lb, dec_sb;

  logic                  req_c, wr_c, ir_ld_c, pc_sel_c, pc_ld_c, rf_wr_c, wd_sel_c;
  logic                  bin_c, rfb_c, lui_c, lb_c, sb_c, timeout_hit;
  logic [ALU_FUNC_W-1:0] func_c;

  ctrl_opdecode #(
    .ALU_FUNC_W (ALU_FUNC_W)
  ) u_opdecode (
    .opcode      (ir[INSTR_W-1 -: 6]),
    .func        (ir[ALU_FUNC_W-1:0]),
    .iclass      (dec_class),
    .legal       (dec_legal),
    .alu_func    (dec_func),
    .alu_bin_sel (dec_bin),
    .rf_b_sel    (dec_rfb),
    .lui         (dec_lui),
    .lb          (dec_lb),
    .sb          (dec_sb)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (ir_ld_c) ir <= mem.Instr;
    end
  end

  // Counts stalled request cycles; any completed access clears it.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
    end else if (MEM_TIMEOUT != 0 && req_c && !mem.Mem_rdy) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    wr_c       = 1'b0;
    ir_ld_c    = 1'b0;
    pc_sel_c   = 1'b0;
    pc_ld_c    = 1'b0;
    rf_wr_c    = 1'b0;
    wd_sel_c   = 1'b0;
    bin_c      = 1'b0;
    rfb_c      = 1'b0;
    func_c     = '0;
    lui_c      = 1'b0;
    lb_c       = 1'b0;
    sb_c       = 1'b0;
    // Mem_rdy in the limit cycle completes the access instead of trapping.
    timeout_hit = (MEM_TIMEOUT != 0) && !mem.Mem_rdy && (wait_cnt == WAIT_LIMIT);

    // ALU controls stay stable from EXEC through MEM and WB.
    if (state inside {S_EXEC, S_MEM, S_WB}) begin
      func_c = dec_func;
      bin_c  = dec_bin;
      rfb_c  = dec_rfb;
      lui_c  = dec_lui;
    end

    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.Mem_rdy) begin
          ir_ld_c    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        if (ir == '0) begin
          pc_ld_c    = 1'b1;
          state_next = S_FETCH;
        end else if (!dec_legal) begin
          state_next = S_ERROR;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_class)
          CLS_B: begin
            pc_sel_c   = 1'b1;
            pc_ld_c    = 1'b1;
            state_next = S_FETCH;
          end
          CLS_BEQ, CLS_BNE: begin
            pc_sel_c   = (dec_class == CLS_BEQ) ? Zero : !Zero;
            pc_ld_c    = 1'b1;
            state_next = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next = S_MEM;
          CLS_ALU:             state_next = S_WB;
          default:             state_next = S_ERROR;
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        if (dec_class == CLS_STORE) begin
          wr_c = 1'b1;
          sb_c = dec_sb;
        end else begin
          lb_c = dec_lb;
        end
        if (mem.Mem_rdy) begin
          if (dec_class == CLS_STORE) begin
            pc_ld_c    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          state_next = S_ERROR;
        end
      end
      S_WB: begin
        rf_wr_c    = 1'b1;
        wd_sel_c   = (dec_class == CLS_LOAD);
        pc_ld_c    = 1'b1;
        state_next = S_FETCH;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
  end

  // Outputs are forced low combinationally while Reset_n is low so an
  // in-flight access is dropped at once, not at the next edge.
  always_comb begin
    mem.Mem_req   = 1'b0;
    mem.Mem_WrEn  = 1'b0;
    IR_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    lui           = 1'b0;
    lb            = 1'b0;
    sb            = 1'b0;
    Trap          = 1'b0;
    State         = 3'd0;
    if (Reset_n) begin
      mem.Mem_req   = req_c;
      mem.Mem_WrEn  = wr_c;
      IR_LdEn       = ir_ld_c;
      PC_sel        = pc_sel_c;
      PC_LdEn       = pc_ld_c;
      RF_WrEn       = rf_wr_c;
      RF_WrData_sel = wd_sel_c;
      RF_B_sel      = rfb_c;
      ALU_Bin_sel   = bin_c;
      ALU_func      = func_c;
      lui           = lui_c;
      lb            = lb_c;
      sb            = sb_c;
      Trap          = (state == S_ERROR);
      State         = state;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Cycle_cnt   <= '0;
      Retired_cnt <= '0;
    end else begin
      if (state != S_ERROR) Cycle_cnt <= Cycle_cnt + 32'd1;
      if (pc_ld_c) Retired_cnt <= Retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle scoreboard bench for multicycle_control.
// Each driven cycle pushes the expected control vector; the negedge monitor
// pops it and compares against the DUT outputs.
module tb_multicycle_control;

  localparam int unsigned TO = 4;

  localparam int T_REQ = 4, T_WR = 3, T_IR = 2, T_PC = 1, T_RF = 0;
  localparam int S_PCSEL = 7, S_WDSEL = 6, S_BIN = 5, S_RFB = 4,
                 S_LUI = 3, S_LB = 2, S_SB = 1, S_TRAP = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] strobe;  // Mem_req, Mem_WrEn, IR_LdEn, PC_LdEn, RF_WrEn
    logic [7:0] sel;     // PC_sel, RF_WrData_sel, ALU_Bin_sel, RF_B_sel, lui, lb, sb, Trap
    logic [3:0] func;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset_n, Zero;
  logic       IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0] ALU_func;
  logic       lui, lb, sb, Trap;
  logic [2:0] State;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] Cycle_cnt, Retired_cnt;
`endif

  multicycle_control_if #(.INSTR_W(32)) bus ();

  multicycle_control #(
    .INSTR_W     (32),
    .ALU_FUNC_W  (4),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .Reset_n       (Reset_n),
    .mem           (bus),
    .Zero          (Zero),
    .IR_LdEn       (IR_LdEn),
    .PC_sel        (PC_sel),
    .PC_LdEn       (PC_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .lui           (lui),
    .lb            (lb),
    .sb            (sb),
    .Trap          (Trap),
    .State         (State)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .Cycle_cnt     (Cycle_cnt),
    .Retired_cnt   (Retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int unsigned n_tests = 0, n_fail = 0, n_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t sample();
    exp_t r;
    r.st     = State;
    r.strobe = {bus.Mem_req, bus.Mem_WrEn, IR_LdEn, PC_LdEn, RF_WrEn};
    r.sel    = {PC_sel, RF_WrData_sel, ALU_Bin_sel, RF_B_sel, lui, lb, sb, Trap};
    r.func   = ALU_func;
    return r;
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
      6'b111111, 6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111,
      6'b011111: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  exp_t mon_got, mon_want;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_want = sb_q.pop_front();
      mon_got  = sample();
      n_cyc++;
      check_eq($sformatf("c%0d state", n_cyc), 32'(mon_got.st), 32'(mon_want.st));
      check_eq($sformatf("c%0d strobes", n_cyc), 32'(mon_got.strobe), 32'(mon_want.strobe));
      check_eq($sformatf("c%0d selects", n_cyc), 32'(mon_got.sel), 32'(mon_want.sel));
      check_eq($sformatf("c%0d alu_func", n_cyc), 32'(mon_got.func), 32'(mon_want.func));
    end
  end

  task automatic step(input logic [31:0] ins, input logic rdy, input logic z, input exp_t e);
    bus.Instr   = ins;
    bus.Mem_rdy = rdy;
    Zero        = z;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; fetch/mem stalls at or beyond TO, an illegal opcode
  // or mem_stop stalls in MEM end the task early (caller continues).
  task automatic do_instr(input logic [31:0] ins, input logic z, input int unsigned fwait,
                          input int unsigned mwait, input int unsigned mem_stop);
    exp_t        e, alu;
    logic [5:0]  op;
    logic [31:0] junk;
    logic        ld, st;
    op   = ins[31:26];
    junk = ~ins;
    ld   = (op == 6'b000011) || (op == 6'b001111);
    st   = (op == 6'b000111) || (op == 6'b011111);
    alu  = '0;
    alu.st         = 3'd2;
    alu.sel[S_BIN] = 1'b1;
    alu.sel[S_RFB] = 1'b1;
    case (op)
      6'b100000: begin
        alu.func       = ins[3:0];
        alu.sel[S_BIN] = 1'b0;
        alu.sel[S_RFB] = 1'b0;
      end
      6'b111001: alu.sel[S_LUI] = 1'b1;
      6'b110010: alu.func = 4'd2;
      6'b110011: alu.func = 4'd3;
      6'b000000, 6'b000001: begin
        alu.func       = 4'd1;
        alu.sel[S_BIN] = 1'b0;
      end
      default: ;
    endcase

    e = '0;
    e.strobe[T_REQ] = 1'b1;
    for (int unsigned i = 0; i < fwait && i < TO; i++) step(ins, 1'b0, ~z, e);
    if (fwait >= TO) return;
    e.strobe[T_IR] = 1'b1;
    step(ins, 1'b1, ~z, e);

    e = '0;
    e.st = 3'd1;
    if (ins == 32'd0) begin
      e.strobe[T_PC] = 1'b1;
      step(junk, 1'b1, ~z, e);
      return;
    end
    step(junk, 1'b1, ~z, e);
    if (!legal_op(op)) return;

    e = alu;
    if (op == 6'b111111 || op == 6'b000000 || op == 6'b000001) begin
      e.strobe[T_PC] = 1'b1;
      e.sel[S_PCSEL] = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? z : ~z;
      step(junk, 1'b1, z, e);
      return;
    end
    step(junk, 1'b1, z, e);

    if (ld || st) begin
      e = alu;
      e.st            = 3'd3;
      e.strobe[T_REQ] = 1'b1;
      e.strobe[T_WR]  = st;
      e.sel[S_SB]     = (op == 6'b000111);
      e.sel[S_LB]     = (op == 6'b000011);
      for (int unsigned i = 0; i < mwait && i < TO && i < mem_stop; i++) step(junk, 1'b0, ~z, e);
      if (mwait >= TO || mem_stop <= mwait) return;
      if (st) begin
        e.strobe[T_PC] = 1'b1;
        step(junk, 1'b1, ~z, e);
        return;
      end
      step(junk, 1'b1, ~z, e);
    end

    e = alu;
    e.st            = 3'd4;
    e.strobe[T_RF]  = 1'b1;
    e.strobe[T_PC]  = 1'b1;
    e.sel[S_WDSEL]  = ld;
    step(junk, 1'b1, ~z, e);
  endtask

  task automatic push_error(input int unsigned n);
    exp_t e;
    e = '0;
    e.st          = 3'd7;
    e.sel[S_TRAP] = 1'b1;
    for (int unsigned i = 0; i < n; i++) step($urandom, (i % 2) == 0, 1'b1, e);
  endtask

  // Entered just after a rising edge; outputs must drop at once and stay low.
  task automatic reset_pulse(input string tag);
    Reset_n     = 1'b0;
    bus.Mem_rdy = 1'b1;
    #1;
    check_eq({tag, " immediate"}, 32'(sample()), 32'd0);
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s hold%0d", tag, i), 32'(sample()), 32'd0);
    end
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    Reset_n     = 1'b0;
    Zero        = 1'b0;
    bus.Instr   = '0;
    bus.Mem_rdy = 1'b0;
    @(posedge clk);
    reset_pulse("reset");

    do_instr({6'b110000, 26'h0A5_0010}, 1'b0, 0, 0, 99);      // addi
    do_instr({6'b100000, 22'h15_5AA3, 4'h6}, 1'b0, 1, 0, 99); // R-type func 6
    do_instr({6'b110010, 26'h012_3456}, 1'b0, 0, 0, 99);      // andi
    do_instr({6'b110011, 26'h065_4321}, 1'b1, 0, 0, 99);      // ori
    do_instr({6'b111000, 26'h000_00FF}, 1'b0, 2, 0, 99);      // li
    do_instr({6'b111001, 26'h000_ABCD}, 1'b0, 0, 0, 99);      // lui
    do_instr({6'b000000, 26'h042_1001}, 1'b1, 0, 0, 99);      // beq taken
    do_instr({6'b000001, 26'h042_1001}, 1'b1, 0, 0, 99);      // bne not taken
    do_instr({6'b000000, 26'h042_1001}, 1'b0, 0, 0, 99);      // beq not taken
    do_instr({6'b000001, 26'h042_1001}, 1'b0, 0, 0, 99);      // bne taken
    do_instr({6'b111111, 26'h000_0040}, 1'b0, 0, 0, 99);      // b
    do_instr(32'd0, 1'b0, 0, 0, 99);                          // nop
    do_instr({6'b001111, 26'h021_0008}, 1'b0, 0, 3, 99);      // lw, 3 stalls
    do_instr({6'b011111, 26'h021_0008}, 1'b0, 0, 0, 99);      // sw
    do_instr({6'b000011, 26'h021_0004}, 1'b0, 0, 1, 99);      // lb
    do_instr({6'b000111, 26'h021_0004}, 1'b0, 1, 2, 99);      // sb
    do_instr({6'b011111, 26'h021_0008}, 1'b0, 0, 3, 99);      // sw, rdy in limit cycle

    do_instr({6'b010101, 26'h000_1234}, 1'b0, 0, 0, 99);      // illegal opcode
    push_error(20);
    reset_pulse("rst after illegal");

    do_instr({6'b110000, 26'h000_0001}, 1'b0, TO, 0, 99);     // fetch timeout
    push_error(3);
    reset_pulse("rst after fetch timeout");
    do_instr({6'b110000, 26'h000_0001}, 1'b0, TO - 1, 0, 99); // rdy in limit cycle

    do_instr({6'b001111, 26'h021_0008}, 1'b0, 0, TO, 99);     // mem timeout
    push_error(3);
    reset_pulse("rst after mem timeout");

    do_instr({6'b011111, 26'h021_0008}, 1'b0, 0, 9, 2);       // reset inside sw MEM
    reset_pulse("rst in sw mem");
    do_instr({6'b110000, 26'h0A5_0010}, 1'b0, 0, 0, 99);

    @(negedge clk);
    check_eq("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
